dense_argmax: RTL and testbench
===============================

Name: dense_argmax

Overview:
- Final classification stage, directly downstream of the dense layer.
- When enabled, reads the OUT_MAX-bounded vector of signed dense results that the dense stage wrote to pixel memory starting at memstartp.
- Tracks the running signed maximum and reports the winning class index (digit) plus its value.
- Raises STOP for the top-level sequencer, using the same level-enable / STOP convention as the other neuroset stages.

Parameters:
- SIZE_1, 12, bit width of one signed activation word (matches dense res width).
- SIZE_address_pix, 13, pixel memory address width.
- RD_LAT, 2, pixel memory read latency in cycles, from read_addressp issue to qp valid; legal 1..4.
- OUT_MAX, 10, maximum class count; out values above this are clamped to OUT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- argmax_en  in  1  level enable; rising level starts a run, dropping aborts or finishes it.
- out  in  4  number of classes to scan (0..15, clamped to OUT_MAX).
- memstartp  in  SIZE_address_pix  base address of dense results.
- re_p  out  1  pixel memory read enable.
- read_addressp  out  SIZE_address_pix  pixel memory read address.
- qp  in  SIZE_1 signed  pixel memory read data.
- digit  out  4  index of maximum (0-based).
- max_val  out  SIZE_1 signed  value at digit.
- valid  out  1  digit/max_val hold a completed result.
- STOP  out  1  run complete; held while argmax_en stays high.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0. Internal issue counter, capture counter, latency pipe, running max/index and state all cleared.
- States:
  - IDLE: wait for argmax_en=1.
  - ISSUE: address issue phase.
  - DRAIN: finish captures after the last issue.
  - DONE: hold result.
- argmax_en=0 in any state returns to IDLE on the next edge. On that edge re_p=0, STOP=0, counters and the pipe clear. digit, max_val and valid keep their last values; valid clears only on the next run start.
- IDLE -> ISSUE on the first edge with argmax_en=1 (edge 0).
  - At edge 0: valid=0, re_p=1, read_addressp=memstartp, running max = most negative SIZE_1 value, index=0.
  - If the clamped out=0: go straight to DONE with STOP=1, valid=0, digit=0, max_val=0.
- ISSUE: at edge k (k=0..N-1, N=clamped out) drive read_addressp=memstartp+k (mod 2^SIZE_address_pix) and push a capture tag into an RD_LAT-deep valid pipe. After edge N-1, re_p=0 and the state moves to DRAIN.
- Capture: at edge k+RD_LAT, qp is sampled as element k.
  - If qp > running max (signed, strict), running max <= qp and index <= k.
  - Ties keep the lower index.
  - The first element always wins, because the running max starts at the most negative value.
- DRAIN -> DONE at edge N+RD_LAT. On that edge: digit=index, max_val=running max, valid=1, STOP=1.
  - Example: N=10, RD_LAT=2 gives STOP high after edge 12.
- DONE: outputs frozen; STOP stays high until argmax_en drops. There is no re-run without argmax_en going low for at least 1 cycle.
- qp is ignored whenever no capture tag is at the pipe head.
- Address arithmetic wraps modulo 2^SIZE_address_pix.
- Comparison width is exactly SIZE_1 signed; there is no saturation.

Optional Feature:
- Macro: DENSE_ARGMAX_MARGIN_EN.
- With the macro defined:
  - Adds output port margin (SIZE_1+1 bits, unsigned) = max_val - second-highest value, registered with digit.
  - Adds output port second_digit (4 bits).
  - The runner-up updates on each capture. A value equal to the max that loses the tie becomes the runner-up, giving margin 0.
  - N=1 gives margin = 2^SIZE_1 - 1 saturated and second_digit=0.
  - Both ports reset to 0.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Memory [3,-5,7,2,7,0,1,-1,4,6], out=10, RD_LAT=2 -> STOP after edge 12, digit=2 (tie at index 4 loses), max_val=7, valid=1. With the macro: margin=0, second_digit=4.
- All ten values = -2048 (SIZE_1=12) -> digit=0, max_val=-2048, valid=1.
- out=0 -> STOP=1 after edge 0, valid=0, digit=0, re_p never asserted.
- out=15 with OUT_MAX=10 -> exactly 10 reads, addresses memstartp..memstartp+9.
- memstartp = 2^13-3 with out=5 -> addresses wrap to 8189,8190,8191,0,1.
- Drop argmax_en at edge 5 of a run -> next edge re_p=0, STOP=0, valid stays 0. Re-enable gives a full fresh run with a correct result.
- Assert rst_n low mid-DRAIN -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dense_argmax.sv
// dense_argmax: final classification stage behind the dense layer.
//
// On a rising argmax_en level it reads `out` signed dense results from pixel
// memory starting at memstartp. `out` is clamped to OUT_MAX. The block tracks
// the running signed maximum and reports the winning class index and its value.
// STOP is raised when the result is ready and stays high until argmax_en drops.
// Dropping argmax_en at any time aborts the run and returns the block to idle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   argmax_en      level enable
//   out            class count (clamped to OUT_MAX)
//   memstartp      base address of the dense results
//   re_p           pixel memory read enable
//   read_addressp  pixel memory read address
//   qp             pixel memory read data (valid RD_LAT cycles after issue)
//   digit          index of the maximum
//   max_val        value at digit
//   valid          digit/max_val hold a completed result
//   STOP           run complete
//
// Optional build macro DENSE_ARGMAX_MARGIN_EN adds these outputs:
//   margin         max_val minus the runner-up value (unsigned, SIZE_1+1 bits)
//   second_digit   index of the runner-up

module dense_argmax #(
    parameter int SIZE_1           = 12,
    parameter int SIZE_address_pix = 13,
    parameter int RD_LAT           = 2,
    parameter int OUT_MAX          = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        argmax_en,
    input  logic [3:0]                  out,
    input  logic [SIZE_address_pix-1:0] memstartp,
    output logic                        re_p,
    output logic [SIZE_address_pix-1:0] read_addressp,
    input  logic signed [SIZE_1-1:0]    qp,
    output logic [3:0]                  digit,
    output logic signed [SIZE_1-1:0]    max_val,
    output logic                        valid,
`ifdef DENSE_ARGMAX_MARGIN_EN
    output logic [SIZE_1:0]             margin,
    output logic [3:0]                  second_digit,
`endif
    output logic                        STOP
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    localparam logic signed [SIZE_1-1:0] MinVal = {1'b1, {(SIZE_1-1){1'b0}}};
    localparam logic [3:0]               OutMax = 4'(OUT_MAX);

    state_e                       state_q, state_d;
    logic [3:0]                   n_q, n_d;
    logic [3:0]                   iss_q, iss_d;
    logic [3:0]                   cap_q, cap_d;
    logic [RD_LAT-1:0]            pipe_q, pipe_d;
    logic [SIZE_address_pix-1:0]  addr_q, addr_d;
    logic                         re_q, re_d;
    logic signed [SIZE_1-1:0]     max_q, max_d;
    logic [3:0]                   idx_q, idx_d;
    logic [3:0]                   digit_q, digit_d;
    logic signed [SIZE_1-1:0]     maxv_q, maxv_d;
    logic                         valid_q, valid_d;
    logic                         stop_q, stop_d;
`ifdef DENSE_ARGMAX_MARGIN_EN
    logic signed [SIZE_1-1:0]     sec_q, sec_d;
    logic [3:0]                   sidx_q, sidx_d;
    logic                         has_sec_q, has_sec_d;
    logic [SIZE_1:0]              margin_q, margin_d;
    logic [3:0]                   sdig_q, sdig_d;
`endif

    logic [3:0] n_clamp;
    logic       capture;
    logic       take_max;

    assign n_clamp = (out > OutMax) ? OutMax : out;
    // Head of the latency pipe marks the cycle where qp belongs to an issued read.
    assign capture = pipe_q[RD_LAT-1];
    // The first element always wins so an all-minimum vector reports index 0.
    assign take_max = (cap_q == 4'd0) || (qp > max_q);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        iss_d   = iss_q;
        cap_d   = cap_q;
        addr_d  = addr_q;
        re_d    = re_q;
        max_d   = max_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        maxv_d  = maxv_q;
        valid_d = valid_q;
        stop_d  = stop_q;
        pipe_d  = '0;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
`ifdef DENSE_ARGMAX_MARGIN_EN
        sec_d     = sec_q;
        sidx_d    = sidx_q;
        has_sec_d = has_sec_q;
        margin_d  = margin_q;
        sdig_d    = sdig_q;
`endif

        if (capture) begin
            cap_d = cap_q + 4'd1;
            if (take_max) begin
                max_d = qp;
                idx_d = cap_q;
`ifdef DENSE_ARGMAX_MARGIN_EN
                // The dethroned maximum becomes the runner-up.
                if (cap_q != 4'd0) begin
                    sec_d     = max_q;
                    sidx_d    = idx_q;
                    has_sec_d = 1'b1;
                end
            end else if (!has_sec_q || (qp > sec_q)) begin
                sec_d     = qp;
                sidx_d    = cap_q;
                has_sec_d = 1'b1;
`endif
            end
        end

        unique case (state_q)
            StIdle: begin
                if (argmax_en) begin
                    valid_d = 1'b0;
                    cap_d   = 4'd0;
                    max_d   = MinVal;
                    idx_d   = 4'd0;
`ifdef DENSE_ARGMAX_MARGIN_EN
                    sec_d     = MinVal;
                    sidx_d    = 4'd0;
                    has_sec_d = 1'b0;
`endif
                    if (n_clamp == 4'd0) begin
                        state_d = StDone;
                        stop_d  = 1'b1;
                        digit_d = 4'd0;
                        maxv_d  = '0;
`ifdef DENSE_ARGMAX_MARGIN_EN
                        margin_d = '0;
                        sdig_d   = 4'd0;
`endif
                    end else begin
                        state_d   = StIssue;
                        n_d       = n_clamp;
                        re_d      = 1'b1;
                        addr_d    = memstartp;
                        iss_d     = 4'd1;
                        pipe_d[0] = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (iss_q < n_q) begin
                    addr_d    = addr_q + 1'b1;
                    iss_d     = iss_q + 4'd1;
                    pipe_d[0] = 1'b1;
                end else begin
                    re_d    = 1'b0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The last capture has landed in max_q/idx_q by the time cap_q reaches n_q.
                if (cap_q == n_q) begin
                    state_d = StDone;
                    digit_d = idx_q;
                    maxv_d  = max_q;
                    valid_d = 1'b1;
                    stop_d  = 1'b1;
`ifdef DENSE_ARGMAX_MARGIN_EN
                    sdig_d   = sidx_q;
                    margin_d = has_sec_q ?
                               ({max_q[SIZE_1-1], max_q} - {sec_q[SIZE_1-1], sec_q}) :
                               {1'b0, {SIZE_1{1'b1}}};
`endif
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase

        // Abort or finish: results are kept, control state is cleared.
        if (!argmax_en) begin
            state_d = StIdle;
            re_d    = 1'b0;
            stop_d  = 1'b0;
            iss_d   = 4'd0;
            cap_d   = 4'd0;
            pipe_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            iss_q   <= '0;
            cap_q   <= '0;
            pipe_q  <= '0;
            addr_q  <= '0;
            re_q    <= 1'b0;
            max_q   <= '0;
            idx_q   <= '0;
            digit_q <= '0;
            maxv_q  <= '0;
            valid_q <= 1'b0;
            stop_q  <= 1'b0;
`ifdef DENSE_ARGMAX_MARGIN_EN
            sec_q     <= '0;
            sidx_q    <= '0;
            has_sec_q <= 1'b0;
            margin_q  <= '0;
            sdig_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            iss_q   <= iss_d;
            cap_q   <= cap_d;
            pipe_q  <= pipe_d;
            addr_q  <= addr_d;
            re_q    <= re_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            maxv_q  <= maxv_d;
            valid_q <= valid_d;
            stop_q  <= stop_d;
`ifdef DENSE_ARGMAX_MARGIN_EN
            sec_q     <= sec_d;
            sidx_q    <= sidx_d;
            has_sec_q <= has_sec_d;
            margin_q  <= margin_d;
            sdig_q    <= sdig_d;
`endif
        end
    end

    assign re_p          = re_q;
    assign read_addressp = addr_q;
    assign digit         = digit_q;
    assign max_val       = maxv_q;
    assign valid         = valid_q;
    assign STOP          = stop_q;
`ifdef DENSE_ARGMAX_MARGIN_EN
    assign margin        = margin_q;
    assign second_digit  = sdig_q;
`endif

endmodule

// File: tb/tb_dense_argmax.sv
// Directed bench for dense_argmax with RD_LAT=2 pixel memory model.
module tb_dense_argmax;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               argmax_en;
    logic [3:0]         out;
    logic [12:0]        memstartp;
    logic               re_p;
    logic [12:0]        read_addressp;
    logic signed [11:0] qp;
    logic [3:0]         digit;
    logic signed [11:0] max_val;
    logic               valid;
    logic               STOP;
`ifdef DENSE_ARGMAX_MARGIN_EN
    logic [12:0]        margin;
    logic [3:0]         second_digit;
`endif

    logic signed [11:0] mem [0:8191];
    logic [12:0]        addr_log[$];
    int                 n_cmp = 0;
    int                 n_bad = 0;

    dense_argmax dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .argmax_en     (argmax_en),
        .out           (out),
        .memstartp     (memstartp),
        .re_p          (re_p),
        .read_addressp (read_addressp),
        .qp            (qp),
        .digit         (digit),
        .max_val       (max_val),
        .valid         (valid),
`ifdef DENSE_ARGMAX_MARGIN_EN
        .margin        (margin),
        .second_digit  (second_digit),
`endif
        .STOP          (STOP)
    );

    always #5 clk = ~clk;

    // Two-cycle memory: address registered by the DUT, data registered here.
    always @(posedge clk) begin
        qp <= mem[read_addressp];
        if (re_p) addr_log.push_back(read_addressp);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raises enable; returns just after edge 0.
    task automatic start_run();
        argmax_en = 1'b1;
        step(1);
    endtask

    task automatic end_run();
        argmax_en = 1'b0;
        step(1);
    endtask

    initial begin
        logic signed [11:0] v1 [0:9];
        logic [12:0]        wrap_addr [0:4];
        v1 = '{12'sd3, -12'sd5, 12'sd7, 12'sd2, 12'sd7, 12'sd0, 12'sd1, -12'sd1, 12'sd4, 12'sd6};
        wrap_addr = '{13'd8189, 13'd8190, 13'd8191, 13'd0, 13'd1};
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        for (int i = 0; i < 10; i++) mem[100 + i] = v1[i];
        for (int i = 0; i < 10; i++) mem[300 + i] = -12'sd2048;
        for (int i = 0; i < 15; i++) mem[200 + i] = 12'(i * 3 - 10);
        mem[210] = 12'sd500;
        mem[8189] = 12'sd1; mem[8190] = 12'sd9; mem[8191] = 12'sd3;
        mem[0] = 12'sd9; mem[1] = -12'sd4;

        // Reset values
        rst_n = 1'b0; argmax_en = 1'b0; out = 4'd0; memstartp = '0;
        #12;
        chk("rst_re_p", re_p, 0);
        chk("rst_stop", STOP, 0);
        chk("rst_valid", valid, 0);
        chk("rst_digit", digit, 0);
        chk("rst_max", {20'b0, max_val}, 0);
        @(negedge clk); rst_n = 1'b1;
        step(1);

        // Basic vector, tie at index 4 loses
        memstartp = 13'd100; out = 4'd10; addr_log.delete();
        start_run();
        chk("t1_re_p_e0", re_p, 1);
        chk("t1_addr_e0", read_addressp, 100);
        chk("t1_valid_e0", valid, 0);
        step(11);
        chk("t1_stop_e11", STOP, 0);
        step(1);
        chk("t1_stop_e12", STOP, 1);
        chk("t1_digit", digit, 2);
        chk("t1_max", {20'b0, max_val}, 7);
        chk("t1_valid", valid, 1);
        chk("t1_reads", addr_log.size(), 10);
`ifdef DENSE_ARGMAX_MARGIN_EN
        chk("t1_margin", margin, 0);
        chk("t1_second", second_digit, 4);
`endif
        step(3);
        chk("t1_stop_hold", STOP, 1);
        end_run();
        chk("t1_stop_drop", STOP, 0);
        chk("t1_valid_kept", valid, 1);
        chk("t1_digit_kept", digit, 2);

        // All minimum values
        memstartp = 13'd300; out = 4'd10;
        start_run();
        step(12);
        chk("t2_digit", digit, 0);
        chk("t2_max", {20'b0, max_val}, 32'h800);
        chk("t2_valid", valid, 1);
        end_run();

        // Zero classes
        out = 4'd0; addr_log.delete();
        start_run();
        chk("t3_stop_e0", STOP, 1);
        chk("t3_valid", valid, 0);
        chk("t3_digit", digit, 0);
        chk("t3_max", {20'b0, max_val}, 0);
        step(4);
        chk("t3_reads", addr_log.size(), 0);
        chk("t3_stop_hold", STOP, 1);
        end_run();

        // out clamped to OUT_MAX
        memstartp = 13'd200; out = 4'd15; addr_log.delete();
        start_run();
        step(14);
        chk("t4_reads", addr_log.size(), 10);
        chk("t4_first", addr_log[0], 200);
        chk("t4_last", addr_log[9], 209);
        chk("t4_digit", digit, 9);
        chk("t4_max", {20'b0, max_val}, 17);
        chk("t4_stop", STOP, 1);
`ifdef DENSE_ARGMAX_MARGIN_EN
        chk("t4_margin", margin, 3);
        chk("t4_second", second_digit, 8);
`endif
        end_run();

        // Address wrap
        memstartp = 13'd8189; out = 4'd5; addr_log.delete();
        start_run();
        step(6);
        chk("t5_stop_e6", STOP, 0);
        step(1);
        chk("t5_stop_e7", STOP, 1);
        chk("t5_reads", addr_log.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t5_addr%0d", i), addr_log[i], wrap_addr[i]);
        chk("t5_digit", digit, 1);
        chk("t5_max", {20'b0, max_val}, 9);
        end_run();

        // Abort at edge 5, then a fresh run
        memstartp = 13'd100; out = 4'd10;
        start_run();
        step(4);
        chk("t6_re_p_e4", re_p, 1);
        argmax_en = 1'b0;
        step(1);
        chk("t6_re_p_abort", re_p, 0);
        chk("t6_stop_abort", STOP, 0);
        chk("t6_valid_abort", valid, 0);
        start_run();
        step(12);
        chk("t6_stop", STOP, 1);
        chk("t6_digit", digit, 2);
        chk("t6_max", {20'b0, max_val}, 7);
        chk("t6_valid", valid, 1);
        end_run();

        // Asynchronous reset in DRAIN
        memstartp = 13'd200; out = 4'd10;
        start_run();
        step(10);
        chk("t7_pre_digit", digit, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_digit", digit, 0);
        chk("t7_max", {20'b0, max_val}, 0);
        chk("t7_re_p", re_p, 0);
        chk("t7_stop", STOP, 0);
        chk("t7_valid", valid, 0);
        argmax_en = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
